// File: rtl/blink_sequencer.sv
// Programmable LED blink controller: counted or continuous on/off sequencing with a config handshake.
// Define BLINK_PAUSE_EN to add a pause input that freezes a running sequence.
module blink_sequencer #(
    parameter int          CNT_W        = 32,
    parameter int          BLINK_W      = 8,
    parameter int unsigned DEFAULT_HALF = 25000000
) (
    input  logic               clk_50MHz,
    input  logic               set_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_half,
    input  logic [BLINK_W-1:0] cfg_blinks,
    input  logic               start,
    input  logic               stop,
`ifdef BLINK_PAUSE_EN
    input  logic               pause,
`endif
    output logic               led,
    output logic               tick,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [CNT_W-1:0]   half_reg, half_next;
    logic [BLINK_W-1:0] blinks_reg, blinks_next;
    logic [BLINK_W-1:0] remaining, remaining_next;
    logic               led_next, tick_next, busy_next, done_next;
    logic               hold;
    logic               phase_end;

`ifdef BLINK_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign phase_end = (count == half_reg - CNT_W'(1));
    assign cfg_ready = (state == ST_IDLE);

    // State register; all outputs are registered alongside it.
    always_ff @(posedge clk_50MHz) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!set_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            half_reg   <= CNT_W'(DEFAULT_HALF);
            blinks_reg <= '0;
            remaining  <= '0;
            led        <= 1'b0;
            tick       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            half_reg   <= half_next;
            blinks_reg <= blinks_next;
            remaining  <= remaining_next;
            led        <= led_next;
            tick       <= tick_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_next     = state;
        count_next     = count;
        half_next      = half_reg;
        blinks_next    = blinks_reg;
        remaining_next = remaining;
        case (state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    half_next   = (cfg_half < CNT_W'(2)) ? CNT_W'(2) : cfg_half;
                    blinks_next = cfg_blinks;
                end
                if (start) begin
                    state_next     = ST_ON;
                    count_next     = '0;
                    remaining_next = cfg_valid ? cfg_blinks : blinks_reg;
                end
            end
            ST_ON, ST_OFF: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else if (!hold) begin
                    if (!phase_end) begin
                        count_next = count + CNT_W'(1);
                    end else begin
                        count_next = '0;
                        if (state == ST_ON) begin
                            state_next = ST_OFF;
                        end else if (blinks_reg == '0) begin
                            state_next = ST_ON;
                        end else if (remaining > BLINK_W'(1)) begin
                            state_next     = ST_ON;
                            remaining_next = remaining - BLINK_W'(1);
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    // Output decode; a tick marks every entry into ON or OFF, done only a natural finish.
    always_comb begin
        led_next  = (state_next == ST_ON);
        busy_next = (state_next != ST_IDLE);
        tick_next = (state_next != state) && (state_next != ST_IDLE);
        done_next = (state == ST_OFF) && (state_next == ST_IDLE) && !stop;
    end

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer: a time-since-start reference model checked every cycle.
// Runs the pause scenario too when built with BLINK_PAUSE_EN.
module tb_blink_sequencer;

    localparam int CNT_W   = 32;
    localparam int BLINK_W = 8;
    localparam int TB_DEF  = 37;

    logic               clk_50MHz = 1'b0;
    logic               set_n     = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_half  = '0;
    logic [BLINK_W-1:0] cfg_blinks = '0;
    logic               start = 1'b0;
    logic               stop  = 1'b0;
    logic               pause = 1'b0;
    logic               led, tick, busy, done;

    int checks   = 0;
    int failures = 0;

    blink_sequencer #(
        .CNT_W       (CNT_W),
        .BLINK_W     (BLINK_W),
        .DEFAULT_HALF(TB_DEF)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .set_n     (set_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_half  (cfg_half),
        .cfg_blinks(cfg_blinks),
        .start     (start),
        .stop      (stop),
`ifdef BLINK_PAUSE_EN
        .pause     (pause),
`endif
        .led       (led),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    always #10 clk_50MHz = ~clk_50MHz;

`ifdef BLINK_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    // Reference model: a run is described by elapsed active cycles t since the start edge.
    bit     m_run = 0;
    longint m_t = 0;
    longint m_half = TB_DEF;
    longint m_blinks = 0;
    bit     m_led = 0, m_tick = 0, m_done = 0;

    task automatic model_edge();
        m_tick = 0;
        m_done = 0;
        if (!set_n) begin
            m_run = 0; m_t = 0; m_half = TB_DEF; m_blinks = 0;
        end else if (!m_run) begin
            if (cfg_valid) begin
                m_half   = (cfg_half < 2) ? 2 : longint'(cfg_half);
                m_blinks = longint'(cfg_blinks);
            end
            if (start) begin
                m_run = 1; m_t = 0; m_tick = 1;
            end
        end else if (stop) begin
            m_run = 0;
        end else if (!(PAUSE_EN && pause)) begin
            m_t++;
            if (m_blinks != 0 && m_t == 2 * m_half * m_blinks) begin
                m_run = 0; m_done = 1;
            end else begin
                if (m_t % m_half == 0) m_tick = 1;
                if (m_blinks == 0 && m_t == 2 * m_half) m_t = 0;
            end
        end
        m_led = m_run && ((m_t / m_half) % 2 == 0);
    endtask

    function automatic logic [4:0] exp_vec();
        return {m_led, m_tick, m_run, m_done, !m_run};
    endfunction

    function automatic logic [4:0] obs_vec();
        return {led, tick, busy, done, cfg_ready};
    endfunction

    // Inputs change only #1 after an edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk_50MHz);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        int high = 0;
        set_n = 0; start = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs_vec() !== 5'b00001) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=00001", i, obs_vec());
            end
        end
        set_n = 1; start = 0;
        step();
        start = 1; step(); start = 0;
        for (int i = 0; i < 3 * TB_DEF && led; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_default cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            high++;
            step();
        end
        checks++;
        if (high != TB_DEF) begin
            failures++;
            $display("FAIL reset_default_half got=%0d exp=%0d", high, TB_DEF);
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_counted();
        int ticks = 0, high = 0, done_at = -1;
        cfg_valid = 1; cfg_half = 4; cfg_blinks = 3; step(); cfg_valid = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL counted cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            if (tick) ticks++;
            if (led) high++;
            if (done && done_at < 0) done_at = i;
            step();
        end
        checks++;
        if (ticks != 6) begin
            failures++;
            $display("FAIL counted_ticks got=%0d exp=6", ticks);
        end
        checks++;
        if (high != 12) begin
            failures++;
            $display("FAIL counted_led_high got=%0d exp=12", high);
        end
        checks++;
        if (done_at != 24) begin
            failures++;
            $display("FAIL counted_done_cycle got=%0d exp=24", done_at);
        end
        checks++;
        if ({busy, cfg_ready} !== 2'b01) begin
            failures++;
            $display("FAIL counted_idle_after got=%b exp=01", {busy, cfg_ready});
        end
    endtask

    task automatic test_continuous();
        int ticks = 0, dones = 0;
        cfg_valid = 1; cfg_half = 2; cfg_blinks = 0; step(); cfg_valid = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 200; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL continuous cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            if (tick) ticks++;
            if (done) dones++;
            step();
        end
        checks++;
        if (ticks != 100 || dones != 0) begin
            failures++;
            $display("FAIL continuous_counts ticks=%0d dones=%0d exp ticks=100 dones=0", ticks, dones);
        end
        stop = 1; step(); stop = 0;
        checks++;
        if ({led, busy, tick, done} !== 4'b0000) begin
            failures++;
            $display("FAIL continuous_stop got=%b exp=0000", {led, busy, tick, done});
        end
    endtask

    task automatic test_stop_boundary();
        cfg_valid = 1; cfg_half = 3; cfg_blinks = 1; step(); cfg_valid = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 5; i++) step();
        stop = 1; step(); stop = 0;
        checks++;
        if (obs_vec() !== 5'b00001 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL stop_boundary got=%b exp=00001", obs_vec());
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL stop_no_done cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_handshake();
        int done_at = -1, high = 0;
        cfg_valid = 1; cfg_half = 3; cfg_blinks = 2; step(); cfg_valid = 0;
        start = 1; step(); start = 0;
        cfg_half = 1; cfg_blinks = 0;
        for (int i = 0; i < 40 && done_at < 0; i++) begin
            cfg_valid = (i < 3);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL handshake_run cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            if (done) done_at = i;
            else step();
        end
        cfg_valid = 0;
        checks++;
        if (done_at != 12) begin
            failures++;
            $display("FAIL handshake_ignored got=%0d exp=12", done_at);
        end
        cfg_valid = 1; cfg_half = 1; cfg_blinks = 1; step(); cfg_valid = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 20 && led; i++) begin
            high++;
            step();
        end
        checks++;
        if (high != 2) begin
            failures++;
            $display("FAIL handshake_clamp got=%0d exp=2", high);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_mid_reset();
        int high = 0;
        cfg_valid = 1; cfg_half = 10; cfg_blinks = 0; step(); cfg_valid = 0;
        start = 1; step(); start = 0;
        for (int i = 0; i < 4; i++) step();
        set_n = 0; step(); set_n = 1;
        checks++;
        if (obs_vec() !== 5'b00001) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=00001", obs_vec());
        end
        start = 1; step(); start = 0;
        for (int i = 0; i < 3 * TB_DEF && led; i++) begin
            high++;
            step();
        end
        checks++;
        if (high != TB_DEF) begin
            failures++;
            $display("FAIL mid_reset_default got=%0d exp=%0d", high, TB_DEF);
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_pause();
        int high = 0;
        cfg_valid = 1; cfg_half = 4; cfg_blinks = 1; step(); cfg_valid = 0;
        start = 1; step(); start = 0;
        if (led) high++;
        for (int i = 0; i < 40; i++) begin
            if (i == 1) pause = 1;
            if (i == 6) pause = 0;
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL pause cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
            if (!led) break;
            high++;
        end
        pause = 0;
        checks++;
        if (high != 9) begin
            failures++;
            $display("FAIL pause_led_high got=%0d exp=9", high);
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            set_n      = ($urandom_range(0, 299) != 0);
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_half   = CNT_W'($urandom_range(0, 6));
            cfg_blinks = BLINK_W'($urandom_range(0, 3));
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            pause      = PAUSE_EN && ($urandom_range(0, 9) == 0);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
            end
        end
        set_n = 1; cfg_valid = 0; start = 0; stop = 0; pause = 0;
    endtask

    initial begin
        test_reset();
        test_counted();
        test_continuous();
        test_stop_boundary();
        test_handshake();
        test_mid_reset();
        if (PAUSE_EN) test_pause();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
